// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter that shares one backing memory
// port between the instruction-fetch (IF) and data-memory (DM) requesters.
//
// DM wins by default. A saturating starvation counter counts DM grants that
// beat a waiting IF. When it reaches STARVE_LIMIT, IF wins the next
// contested arbitration.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_req_*            IF read request (valid/ready handshake, address)
//   if_resp_*           IF read response (one-cycle valid pulse plus data)
//   dm_req_*            DM request (valid/ready, wen, address, wdata, wmask)
//   dm_resp_*           DM response (one-cycle pulse; data is 0 for writes)
//   mem_req_*           request to the backing memory (valid/ready handshake)
//   mem_resp_*          memory response or write acknowledge
//   busy                high while a transaction is outstanding (not IDLE)
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [DATA_W-1:0]     if_resp_data,

  input  logic                  dm_req_valid,
  input  logic                  dm_req_wen,
  input  logic [ADDR_W-1:0]     dm_req_addr,
  input  logic [DATA_W-1:0]     dm_req_wdata,
  input  logic [DATA_W/8-1:0]   dm_req_wmask,
  output logic                  dm_req_ready,
  output logic                  dm_resp_valid,
  output logic [DATA_W-1:0]     dm_resp_data,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,

  output logic                  busy
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [3:0]          starveCnt;
  logic [3:0]          starveCntNext;
  logic                ownerDm;
  logic                grantIf;
  logic                grantDm;

  logic                reqWen;
  logic [ADDR_W-1:0]   reqAddr;
  logic [DATA_W-1:0]   reqWdata;
  logic [MASK_W-1:0]   reqWmask;

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  // Arbitration and next state. Grants are gated by rst so that both
  // readies stay low while reset is asserted.
  always_comb begin
    grantIf       = 1'b0;
    grantDm       = 1'b0;
    stateNext     = state;
    starveCntNext = starveCnt;

    unique case (state)
      IDLE: begin
        if (rst) begin
          if (dm_req_valid && !(if_req_valid && (starveCnt == LIMIT))) begin
            grantDm = 1'b1;
          end else if (if_req_valid) begin
            grantIf = 1'b1;
          end
        end

        if (grantDm || grantIf) begin
          stateNext = REQ;
        end

        if (grantIf) begin
          starveCntNext = '0;
        end else if (grantDm && if_req_valid && (starveCnt != LIMIT)) begin
          starveCntNext = starveCnt + 4'd1;
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          stateNext = RESP;
        end
      end

      RESP: begin
        if (mem_resp_valid) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Request fields are latched at the grant edge, so requesters may change
  // them as soon as they see ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ownerDm  <= 1'b0;
      reqWen   <= 1'b0;
      reqAddr  <= '0;
      reqWdata <= '0;
      reqWmask <= '0;
    end else if (grantDm) begin
      ownerDm  <= 1'b1;
      reqWen   <= dm_req_wen;
      reqAddr  <= dm_req_addr;
      reqWdata <= dm_req_wdata;
      reqWmask <= dm_req_wmask;
    end else if (grantIf) begin
      ownerDm  <= 1'b0;
      reqWen   <= 1'b0;
      reqAddr  <= if_req_addr;
      reqWdata <= '0;
      reqWmask <= '0;
    end
  end

  // Response routing. The pulse appears in the cycle after the memory
  // response, when the FSM is already back in IDLE. Each port's data holds
  // until that port's next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      dm_resp_valid <= 1'b0;
      dm_resp_data  <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      dm_resp_valid <= 1'b0;
      if ((state == RESP) && mem_resp_valid) begin
        if (ownerDm) begin
          dm_resp_valid <= 1'b1;
          dm_resp_data  <= reqWen ? '0 : mem_resp_data;
        end else begin
          if_resp_valid <= 1'b1;
          if_resp_data  <= mem_resp_data;
        end
      end
    end
  end

  assign if_req_ready  = grantIf;
  assign dm_req_ready  = grantDm;

  assign mem_req_valid = (state == REQ);
  assign mem_req_wen   = reqWen;
  assign mem_req_addr  = reqAddr;
  assign mem_req_wdata = reqWdata;
  assign mem_req_wmask = reqWmask;

  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic            clk;
  logic            rst;
  logic            if_req_valid;
  logic [AW-1:0]   if_req_addr;
  logic            if_req_ready;
  logic            if_resp_valid;
  logic [DW-1:0]   if_resp_data;
  logic            dm_req_valid;
  logic            dm_req_wen;
  logic [AW-1:0]   dm_req_addr;
  logic [DW-1:0]   dm_req_wdata;
  logic [DW/8-1:0] dm_req_wmask;
  logic            dm_req_ready;
  logic            dm_resp_valid;
  logic [DW-1:0]   dm_resp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_wen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_data;
  logic            busy;

  // Memory side: automatic responder or manual drive from the main sequence.
  logic            memAuto;
  int              memStall;
  logic            autoReady;
  logic            autoRespValid;
  logic [DW-1:0]   autoRespData;
  logic            manReady;
  logic            manRespValid;
  logic [DW-1:0]   manRespData;

  assign mem_req_ready  = memAuto ? autoReady     : manReady;
  assign mem_resp_valid = memAuto ? autoRespValid : manRespValid;
  assign mem_resp_data  = memAuto ? autoRespData  : manRespData;

  typedef struct {
    logic            wen;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
  } reqT;

  reqT             expReqQ[$];
  logic [DW-1:0]   ifQ[$];
  logic [DW-1:0]   dmQ[$];

  int              checks;
  int              errors;
  int              cyc;
  int              ifRespCyc;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req_valid(if_req_valid),
    .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid),
    .if_resp_data(if_resp_data),
    .dm_req_valid(dm_req_valid),
    .dm_req_wen(dm_req_wen),
    .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata),
    .dm_req_wmask(dm_req_wmask),
    .dm_req_ready(dm_req_ready),
    .dm_resp_valid(dm_resp_valid),
    .dm_resp_data(dm_resp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Contents of the modelled memory.
  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013_0000_0013;
    return (a * 64'd3) ^ 64'hA5A5_0000_5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectIf(input logic [AW-1:0] a);
    reqT r;
    r.wen = 1'b0; r.addr = a; r.wdata = '0; r.wmask = '0;
    expReqQ.push_back(r);
    ifQ.push_back(memData(a));
  endtask

  task automatic expectDm(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW/8-1:0] wm);
    reqT r;
    r.wen = w; r.addr = a; r.wdata = wd; r.wmask = wm;
    expReqQ.push_back(r);
    dmQ.push_back(w ? '0 : memData(a));
  endtask

  task automatic waitReady(input bit dm, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dm ? dm_req_ready : if_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifQ.size() == 0 && dmQ.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (if_resp_valid) begin
        ifRespCyc = cyc;
        if (ifQ.size() == 0) chk("ifRespUnexpected", 1'b1, 1'b0);
        else chk("ifRespData", if_resp_data, ifQ.pop_front());
      end
      if (dm_resp_valid) begin
        if (dmQ.size() == 0) chk("dmRespUnexpected", 1'b1, 1'b0);
        else chk("dmRespData", dm_resp_data, dmQ.pop_front());
      end
    end
  end

  // Automatic memory: checks each REQ-cycle request against the expected
  // queue, accepts after memStall cycles, responds in the following cycle.
  initial begin : memModel
    bit            pend;
    int            waitCnt;
    logic [AW-1:0] pAddr;
    logic          pWen;
    reqT           e;
    pend = 1'b0; waitCnt = 0; pAddr = '0; pWen = 1'b0;
    autoReady = 1'b0; autoRespValid = 1'b0; autoRespData = '0;
    forever begin
      @(posedge clk); #1;
      autoReady = 1'b0; autoRespValid = 1'b0; autoRespData = '0;
      if (!memAuto || !rst) begin
        pend = 1'b0;
        waitCnt = 0;
      end else if (pend) begin
        autoRespValid = 1'b1;
        autoRespData  = pWen ? 64'hBAD0_C0FF_EE00_0BAD : memData(pAddr);
        pend = 1'b0;
      end else if (mem_req_valid) begin
        if (expReqQ.size() == 0) begin
          chk("memReqUnexpected", 1'b1, 1'b0);
        end else begin
          e = expReqQ[0];
          chk("memReqCtl", {mem_req_wen, mem_req_wmask, mem_req_addr}, {e.wen, e.wmask, e.addr});
          if (e.wen) chk("memReqWdata", mem_req_wdata, e.wdata);
        end
        if (waitCnt >= memStall) begin
          autoReady = 1'b1;
          pend = 1'b1;
          pAddr = mem_req_addr;
          pWen = mem_req_wen;
          waitCnt = 0;
          if (expReqQ.size() != 0) void'(expReqQ.pop_front());
        end else begin
          waitCnt++;
        end
      end
    end
  end

  initial begin : mainSeq
    bit         expDm[6];
    logic [3:0] expCnt[6];
    logic [AW-1:0] ifA;
    logic [AW-1:0] dmA;
    int t;

    expDm  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    expCnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    checks = 0; errors = 0; ifRespCyc = -1;
    rst = 1'b1;
    memAuto = 1'b0; memStall = 0;
    manReady = 1'b0; manRespValid = 1'b0; manRespData = '0;
    if_req_valid = 1'b1; if_req_addr = 64'h44;
    dm_req_valid = 1'b1; dm_req_wen = 1'b1; dm_req_addr = 64'h88;
    dm_req_wdata = 64'h1; dm_req_wmask = 8'hFF;

    // Reset with both requesters valid: everything must read 0.
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("resetReady", {if_req_ready, dm_req_ready}, 2'b00);
    chk("resetResp", {if_resp_valid, dm_resp_valid, if_resp_data, dm_resp_data}, '0);
    chk("resetMemReq", {mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr}, '0);
    chk("resetWdata", mem_req_wdata, '0);
    chk("resetBusy", busy, 1'b0);
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Reset in the middle of RESP; the late memory response is ignored.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h40;
    waitReady(1'b0, "t1IfReady");
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    chk("t1ReqValid", {mem_req_valid, mem_req_addr}, {1'b1, 64'h40});
    manReady = 1'b1;
    @(posedge clk); #1;
    manReady = 1'b0;
    chk("t1BusyResp", {busy, mem_req_valid}, 2'b10);
    @(negedge clk); rst = 1'b0; #1;
    chk("t1AsyncReset", {busy, mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr}, '0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    manRespValid = 1'b1; manRespData = 64'h1234_5678;
    @(posedge clk); #1;
    manRespValid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t1AfterResp", {busy, if_resp_valid, dm_resp_valid, mem_req_valid, mem_req_addr}, '0);
    end

    // IF-only read, minimum latency.
    memAuto = 1'b1; memStall = 0;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    waitReady(1'b0, "t2IfReady");
    chk("t2DmReadyLow", dm_req_ready, 1'b0);
    expectIf(64'h8000_0000);
    t = cyc;
    @(posedge clk); #1;
    if_req_valid = 1'b0; if_req_addr = 64'hFFFF;
    @(negedge clk);
    chk("t2MemReqT1", {mem_req_valid, mem_req_wen, mem_req_addr}, {1'b1, 1'b0, 64'h8000_0000});
    drain("t2Drain");
    chk("t2RespLatency", ifRespCyc, t + 3);

    // DM write with three stall cycles; response data must be 0.
    memStall = 3;
    @(posedge clk); #1;
    dm_req_valid = 1'b1; dm_req_wen = 1'b1; dm_req_addr = 64'h100;
    dm_req_wdata = 64'hDEAD_BEEF; dm_req_wmask = 8'h0F;
    waitReady(1'b1, "t3DmReady");
    expectDm(1'b1, 64'h100, 64'hDEAD_BEEF, 8'h0F);
    @(posedge clk); #1;
    dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0; dm_req_wen = 1'b0;
    drain("t3Drain");
    chk("t3RespDataHold", dm_resp_data, '0);

    // mem_resp_valid while still in REQ is ignored.
    memAuto = 1'b0; memStall = 0;
    @(posedge clk); #1;
    dm_req_valid = 1'b1; dm_req_wen = 1'b0; dm_req_addr = 64'h200;
    waitReady(1'b1, "t4DmReady");
    dmQ.push_back(64'hCAFE_0000_0000_0200);
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    manRespValid = 1'b1; manRespData = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    manRespValid = 1'b0;
    chk("t4StillReq", {busy, mem_req_valid, dm_resp_valid}, 3'b110);
    manReady = 1'b1;
    @(posedge clk); #1;
    manReady = 1'b0;
    manRespValid = 1'b1; manRespData = 64'hCAFE_0000_0000_0200;
    @(posedge clk); #1;
    manRespValid = 1'b0;
    drain("t4Drain");

    // Both requesters continuously valid: starvation counter forces IF.
    memAuto = 1'b1; memStall = 0;
    ifA = 64'h1000; dmA = 64'h2000;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = ifA;
    dm_req_valid = 1'b1; dm_req_wen = 1'b0; dm_req_addr = dmA;
    for (int i = 0; i < 6; i++) begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (if_req_ready || dm_req_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("t5GrantSeen", ok, 1'b1);
      chk("t5GrantOrder", {dm_req_ready, if_req_ready}, {expDm[i], !expDm[i]});
      if (dm_req_ready) expectDm(1'b0, dmA, '0, '0);
      else if (if_req_ready) expectIf(ifA);
      @(posedge clk); #1;
      chk("t5StarveCnt", dut.starveCnt, expCnt[i]);
      if (expDm[i]) begin dmA = dmA + 64'h8; dm_req_addr = dmA; end
      else begin ifA = ifA + 64'h4; if_req_addr = ifA; end
      if (i == 5) begin
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
      end
    end
    drain("t5Drain");

    // Back-to-back IF then DM: DM is granted in the IF response cycle.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h3000;
    waitReady(1'b0, "t6IfReady");
    expectIf(64'h3000);
    t = cyc;
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b1; dm_req_wen = 1'b0; dm_req_addr = 64'h3008;
    waitReady(1'b1, "t6DmReady");
    chk("t6SameCycle", {if_resp_valid, dm_resp_valid, cyc}, {1'b1, 1'b0, t + 3});
    expectDm(1'b0, 64'h3008, '0, '0);
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    drain("t6Drain");

    repeat (3) @(negedge clk);
    chk("queuesEmpty", ifQ.size() + dmQ.size() + expReqQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-outstanding arbiter that shares one backing memory port between instruction fetch (IF) and data memory (DM) requesters of the 64-bit pipeline.
- Sits between the fetch/memory stages and the memory interface.
- Asserts busy so the pipeline controller can stall.
- DM has priority by default; a starvation counter guarantees IF forward progress.

Parameters:
ADDR_W  64  address width of all request ports
DATA_W  64  data width of read/write data
STARVE_LIMIT  4  consecutive DM grants that lose to a waiting IF before IF is forced to win (1..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
if_req_valid  input  1  IF read request valid
if_req_addr  input  ADDR_W  IF read address
if_req_ready  output  1  IF request accepted this cycle
if_resp_valid  output  1  one-cycle pulse, IF read data valid
if_resp_data  output  DATA_W  IF read data
dm_req_valid  input  1  DM request valid
dm_req_wen  input  1  1 = write, 0 = read
dm_req_addr  input  ADDR_W  DM address
dm_req_wdata  input  DATA_W  DM write data
dm_req_wmask  input  DATA_W/8  DM byte write mask
dm_req_ready  output  1  DM request accepted this cycle
dm_resp_valid  output  1  one-cycle pulse, DM read data / write ack
dm_resp_data  output  DATA_W  DM read data (0 for writes)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_wen  output  1  write enable
mem_req_addr  output  ADDR_W  address
mem_req_wdata  output  DATA_W  write data
mem_req_wmask  output  DATA_W/8  byte mask
mem_resp_valid  input  1  memory response / write ack
mem_resp_data  input  DATA_W  memory read data
busy  output  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; starve_cnt=0; owner=IF.
  - All outputs 0, including latched mem_req_* fields and resp data.
  - An in-flight memory transaction is abandoned; a later mem_resp_valid is ignored in IDLE.
- FSM states IDLE, REQ, RESP. Exactly one transaction outstanding.
- IDLE arbitration, combinational within the cycle:
  - Only DM valid -> grant DM. Only IF valid -> grant IF.
  - Both valid -> grant DM, unless starve_cnt==STARVE_LIMIT, in which case grant IF.
  - Winner's *_req_ready=1 for that cycle only. Loser's ready=0.
  - On a grant, at the clock edge: latch addr/wen/wdata/wmask and owner, then go to REQ.
  - IF requests latch wen=0, wmask=0.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) when DM is granted while if_req_valid=1.
  - Cleared to 0 when IF is granted.
  - Unchanged otherwise.
- Ready is only ever asserted in IDLE. Both *_req_ready are 0 in REQ and RESP.
- Requesters hold valid and fields until ready. Fields are don't-care after acceptance because they are latched.
- REQ:
  - mem_req_valid=1, mem_req_* driven from the latches and stable until mem_req_ready.
  - On mem_req_ready=1 -> RESP, with mem_req_valid=0 from the next cycle.
- RESP:
  - Wait for mem_resp_valid.
  - On mem_resp_valid=1 -> IDLE. Next cycle the owner's resp_valid=1 for exactly one cycle.
  - resp_data for that pulse: mem_resp_data captured at that edge, or 0 for a DM write.
  - The non-owner's resp_valid stays 0.
- mem_resp_valid in IDLE or REQ is ignored (protocol error, no state change).
- Minimum latency: accept at cycle t, mem_req_valid at t+1, mem_req_ready at t+1, mem_resp_valid at t+2, resp_valid at t+3.
- Back-to-back: in the cycle the resp pulse is visible the FSM is already in IDLE, so a new grant may occur in that same cycle.
- resp_data holds its value until the next response for that port.
- busy=1 in REQ and RESP; 0 in IDLE and during reset.

Test Plan:
- Reset mid-RESP (rst low 1 cycle), then mem_resp_valid=1 -> no resp_valid on either port, state IDLE, busy=0, all mem_req_* = 0.
- IF-only read of addr 0x8000_0000, mem_req_ready=1 immediately, mem_resp_data=0x0000_0013_0000_0013 one cycle later:
  - if_req_ready at t.
  - mem_req_valid at t+1 with addr 0x8000_0000, wen=0.
  - if_resp_valid at t+3 with data 0x0000_0013_0000_0013; dm_resp_valid stays 0.
- DM write addr 0x100, wdata 0xDEAD_BEEF, wmask 0x0F, with mem_req_ready held 0 for 3 cycles:
  - mem_req fields stable across the 3 stall cycles.
  - After the ack, dm_resp_valid=1 with dm_resp_data=0.
- IF and DM both continuously valid, STARVE_LIMIT=4:
  - Grant order DM, DM, DM, DM, IF, DM, ...
  - starve_cnt 1, 2, 3, 4, 0, 1.
- mem_resp_valid pulsed during REQ (before mem_req_ready) -> ignored: state stays REQ, no resp pulse.
- Back-to-back IF then DM reads with zero memory wait:
  - DM's dm_req_ready is asserted in the same cycle as if_resp_valid.
  - Each response is routed only to its owner.
